instr_fetch: RTL and testbench

Instruction fetch unit for the SCC pipeline. Holds the program counter and issues word requests to instruction memory over a request/grant, in-order response interface. Buffers returned words in a small FIFO and presents the head instruction and its successor to instruction decode under a valid/ready handshake. Handles branch redirects by flushing the FIFO and discarding in-flight responses, and stops fetching on a halt request.

---
 rtl/scc_pkg.sv | 17 +
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fifo.sv | 57 +++++
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | scc_pkg -- shared SCC types and constants  | rev 1.0         |
// +--------------------------------------------------------------+
package scc_pkg;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] INSTR_NOP  = 32'hC800_0000;
  localparam logic [INSTR_W-1:0] INSTR_HALT = 32'hD000_0000;

  typedef enum logic [0:0] {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;
endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------+
// | instr_fetch_if -- instruction memory req/gnt bus | rev 1.0   |
// +--------------------------------------------------------------+
interface instr_fetch_if #(
  parameter int ADDR_W = 16
);
  logic                        imem_req;
  logic [ADDR_W-1:0]           imem_addr;
  logic                        imem_gnt;
  logic                        imem_rvalid;
  logic [scc_pkg::INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------+
// | instr_fifo -- sync FIFO exposing head and head+1 | rev 1.0   |
// +--------------------------------------------------------------+
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic                       flush,
  input  wire logic [WIDTH-1:0]           din,
  output logic      [WIDTH-1:0]           head,
  output logic      [WIDTH-1:0]           head_next,
  output logic      [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  // Flush wins over both push and pop in the same cycle.
  assign w_push = push && !flush;
  assign w_pop  = pop && !flush && (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem[r_wr_ptr] <= din;
  end

  assign head      = mem[r_rd_ptr];
  assign head_next = mem[r_rd_ptr + PW'(1)];
  assign count     = r_cnt;
endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------+
// | instr_fetch -- PC, credit-limited fetch, decode FIFO | rev 1.0 |
// +--------------------------------------------------------------+
module instr_fetch
  import scc_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  instr_fetch_if.master           imem,
  input  wire logic               redirect,
  input  wire logic [ADDR_W-1:0]  redirect_pc,
  input  wire logic               halt,
  output logic                    instr_valid,
  output logic [INSTR_W-1:0]      instr,
  output logic [ADDR_W-1:0]       instr_pc,
  output logic                    instr_next_valid,
  output logic [INSTR_W-1:0]      instr_next,
  input  wire logic               instr_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = INSTR_W + ADDR_W;

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CW-1:0]     r_outs;
  logic [CW-1:0]     r_drop;
  logic [CW-1:0]     w_outs_next;
  logic [CW-1:0]     w_count;
  logic              w_credit;
  logic              w_fire;
  logic              w_push;
  logic              w_pop;
  logic [FW-1:0]     w_head;
  logic [FW-1:0]     w_head_next;

  assign w_credit = ({1'b0, w_count} + {1'b0, r_outs}) < (CW+1)'(DEPTH);
  assign imem.imem_req  = rst_n && (r_state == FS_RUN) && !redirect && w_credit;
  assign imem.imem_addr = r_pc;

  assign w_fire      = imem.imem_req && imem.imem_gnt;
  assign w_outs_next = r_outs + CW'(w_fire) - CW'(imem.imem_rvalid);
  assign w_push      = imem.imem_rvalid && !redirect && (r_drop == '0);
  assign w_pop       = instr_valid && instr_ready;

  always_comb begin
    w_state_next = r_state;
    if (halt) w_state_next = FS_HALT;
  end

  // Responses are in order, so every kept response belongs to the next
  // sequential address after the last redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FS_RUN;
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_outs   <= '0;
      r_drop   <= '0;
    end else begin
      r_state <= w_state_next;
      r_outs  <= w_outs_next;
      if (redirect) begin
        r_pc     <= redirect_pc;
        r_rsp_pc <= redirect_pc;
        r_drop   <= w_outs_next;
      end else begin
        if (w_fire) r_pc <= r_pc + ADDR_W'(1);
        if (w_push) r_rsp_pc <= r_rsp_pc + ADDR_W'(1);
        if (imem.imem_rvalid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
      end
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .flush     (redirect),
    .din       ({imem.imem_rdata, r_rsp_pc}),
    .head      (w_head),
    .head_next (w_head_next),
    .count     (w_count)
  );

  assign instr_valid      = (w_count != '0);
  assign instr_next_valid = (w_count >= CW'(2));
  assign instr            = instr_valid      ? w_head[FW-1 -: INSTR_W]      : '0;
  assign instr_pc         = instr_valid      ? w_head[ADDR_W-1:0]           : '0;
  assign instr_next       = instr_next_valid ? w_head_next[FW-1 -: INSTR_W] : '0;
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_instr_fetch -- randomized bench with queue-based model | rev 1.0 |
// +--------------------------------------------------------------+
module tb_instr_fetch;
  localparam int          AW    = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_next_valid;
  logic [31:0] instr_next;
  logic        instr_ready;

  instr_fetch_if #(.ADDR_W(AW)) bus ();

  instr_fetch #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (bus.master),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .halt             (halt),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_next_valid (instr_next_valid),
    .instr_next       (instr_next),
    .instr_ready      (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; int due; } req_t;

  // Model state: memory in flight, words waiting for decode, PC, drop count.
  req_t        mq[$];
  logic [15:0] m_fifo[$];
  logic [15:0] m_pc;
  int          m_drop;
  bit          m_halted;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int gnt_pct, rv_pct, rdy_pct, lat_min, lat_max;
  bit do_redir = 0, do_halt = 0;
  logic [15:0] redir_tgt = 16'h0;

  logic        s_req, s_valid, s_nvalid;
  logic [15:0] s_addr, s_pc;
  logic [31:0] s_instr;
  int          s_cyc;

  function automatic logic [31:0] word(input logic [15:0] a);
    return 32'hA000_0000 + {16'h0000, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_fifo.delete();
    m_pc     = RPC;
    m_drop   = 0;
    m_halted = 0;
  endtask

  task automatic reset_dut(input bit check_outputs);
    rst_n = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0; instr_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (check_outputs) begin
      chk("rst_req",    bus.imem_req,     1'b0);
      chk("rst_addr",   bus.imem_addr,    RPC);
      chk("rst_valid",  instr_valid,      1'b0);
      chk("rst_instr",  instr,            32'h0);
      chk("rst_pc",     instr_pc,         16'h0);
      chk("rst_nvalid", instr_next_valid, 1'b0);
      chk("rst_next",   instr_next,       32'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
  endtask

  // One clock: drive inputs, compare at negedge, advance the model.
  task automatic step();
    logic exp_req, exp_valid, exp_nvalid, fire, pop, rv;
    req_t item;
    rv = (mq.size() > 0) && (mq[0].due <= cyc) && ($urandom_range(99) < rv_pct);
    bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? word(mq[0].addr) : $urandom;
    instr_ready     = ($urandom_range(99) < rdy_pct);
    redirect        = do_redir;
    redirect_pc     = do_redir ? redir_tgt : 16'($urandom);
    halt            = do_halt;
    do_redir = 0;
    do_halt  = 0;

    @(negedge clk);
    exp_req    = !m_halted && !redirect && ((m_fifo.size() + mq.size()) < DEPTH);
    exp_valid  = m_fifo.size() > 0;
    exp_nvalid = m_fifo.size() > 1;
    chk("imem_req",    bus.imem_req,     exp_req);
    chk("imem_addr",   bus.imem_addr,    m_pc);
    chk("instr_valid", instr_valid,      exp_valid);
    chk("instr_pc",    instr_pc,         exp_valid ? m_fifo[0] : 16'h0);
    chk("instr",       instr,            exp_valid ? word(m_fifo[0]) : 32'h0);
    chk("next_valid",  instr_next_valid, exp_nvalid);
    chk("instr_next",  instr_next,       exp_nvalid ? word(m_fifo[1]) : 32'h0);
    s_req = bus.imem_req; s_addr = bus.imem_addr; s_valid = instr_valid;
    s_pc = instr_pc; s_instr = instr; s_nvalid = instr_next_valid; s_cyc = cyc;

    fire = exp_req && bus.imem_gnt;
    pop  = exp_valid && instr_ready;
    item = '{addr: 16'h0, due: 0};
    if (rv) item = mq.pop_front();
    if (fire) mq.push_back('{addr: m_pc, due: cyc + $urandom_range(lat_max, lat_min)});
    if (redirect) begin
      m_fifo.delete();
      m_pc   = redirect_pc;
      m_drop = mq.size();
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else m_fifo.push_back(item.addr);
      end
      if (fire) m_pc = m_pc + 16'd1;
    end
    if (halt) m_halted = 1;

    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic set_mode(input int g, input int r, input int d, input int lmin, input int lmax);
    gnt_pct = g; rv_pct = r; rdy_pct = d; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int delivered;
    rst_n = 1'b0;
    set_mode(100, 100, 100, 1, 1);
    reset_dut(1);

    // Streaming: one instruction per cycle from address 0.
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_cyc >= 2 && s_cyc <= 5) begin
        chk("seq_valid", s_valid, 1'b1);
        chk("seq_pc",    s_pc,    16'(s_cyc - 2));
        chk("seq_instr", s_instr, 32'hA000_0000 + 32'(s_cyc - 2));
      end
    end

    // Decode stalls: FIFO fills and requests stop.
    set_mode(100, 100, 0, 1, 1);
    repeat (10) step();
    chk("stall_req",    s_req,    1'b0);
    chk("stall_nvalid", s_nvalid, 1'b1);

    // Redirect with two responses still in flight.
    set_mode(50, 100, 100, 3, 3);
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (mq.size() == 2) found = 1;
      else step();
    end
    chk("redir_setup", found, 1'b1);
    do_redir = 1; redir_tgt = 16'h0040;
    step();
    step();
    chk("redir_t1_valid", s_valid, 1'b0);
    chk("redir_t1_req",   s_req,   1'b1);
    chk("redir_t1_addr",  s_addr,  16'h0040);
    step();
    chk("redir_t2_valid", s_valid, 1'b0);
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (s_valid) found = 1;
    end
    chk("redir_found", found, 1'b1);
    chk("redir_first_pc", s_pc, 16'h0040);

    // Redirect coinciding with a response and a pop.
    set_mode(100, 100, 100, 1, 1);
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (m_fifo.size() > 0 && mq.size() > 0 && mq[0].due <= cyc) found = 1;
      else step();
    end
    chk("coinc_setup", found, 1'b1);
    do_redir = 1; redir_tgt = 16'h1234;
    step();
    step();
    chk("coinc_flush", s_valid, 1'b0);

    // Random traffic with occasional redirects.
    set_mode(70, 70, 60, 1, 4);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 3) begin
        do_redir  = 1;
        redir_tgt = 16'($urandom);
      end
      step();
    end

    // Halt with two outstanding; a redirect while halted must not restart.
    set_mode(100, 100, 100, 3, 3);
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (mq.size() == 2) found = 1;
      else step();
    end
    chk("halt_setup", found, 1'b1);
    do_halt = 1;
    step();
    delivered = 0;
    for (int n = 0; n < 30; n++) begin
      if (n == 15) begin do_redir = 1; redir_tgt = 16'h0100; end
      step();
      if (s_valid && instr_ready) delivered++;
    end
    chk("halt_drain", delivered >= 2, 1'b1);
    chk("halt_req",   s_req,   1'b0);
    chk("halt_valid", s_valid, 1'b0);
    chk("halt_addr",  s_addr,  16'h0100);

    // PC wrap from 0xFFFF.
    reset_dut(0);
    set_mode(100, 100, 100, 1, 1);
    do_redir = 1; redir_tgt = 16'hFFFF;
    step();
    step();
    chk("wrap_req",  s_req,  1'b1);
    chk("wrap_addr", s_addr, 16'hFFFF);
    step();
    chk("wrap_next", s_addr, 16'h0000);
    set_mode(80, 80, 70, 1, 3);
    repeat (200) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
